// File: rtl/register_access_pkg.sv
// register_access_pkg: shared widths, default timeout and FSM encoding for the register access initiator.
`default_nettype none
package register_access_pkg;
  localparam int unsigned ADDR_W                 = 19;
  localparam int unsigned DATA_W                 = 32;
  localparam int unsigned CNT_W                  = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } state_t;
endpackage
`default_nettype wire

// File: rtl/register_access_initiator_if.sv
// register_access_initiator_if: host request/completion and bus command/response signals.
`default_nettype none
interface register_access_initiator_if;
  import register_access_pkg::*;

  logic              i_req_valid;
  logic              i_req_rd;
  logic [ADDR_W-1:0] iv_req_addr;
  logic              i_req_addr_fixed;
  logic [DATA_W-1:0] iv_req_wdata;
  logic              o_req_ready;
  logic              o_wr;
  logic              o_rd;
  logic [ADDR_W-1:0] ov_addr;
  logic              o_addr_fixed;
  logic [DATA_W-1:0] ov_wdata;
  logic              i_rsp_wr;
  logic [ADDR_W-1:0] iv_rsp_addr;
  logic              i_rsp_addr_fixed;
  logic [DATA_W-1:0] iv_rsp_rdata;
  logic              o_rsp_valid;
  logic [DATA_W-1:0] ov_rsp_rdata;
  logic              o_rsp_err;
  logic [CNT_W-1:0]  ov_timeout_cnt;

  modport master (
    input  i_req_valid, i_req_rd, iv_req_addr, i_req_addr_fixed, iv_req_wdata,
    input  i_rsp_wr, iv_rsp_addr, i_rsp_addr_fixed, iv_rsp_rdata,
    output o_req_ready, o_wr, o_rd, ov_addr, o_addr_fixed, ov_wdata,
    output o_rsp_valid, ov_rsp_rdata, o_rsp_err, ov_timeout_cnt
  );

  modport slave (
    output i_req_valid, i_req_rd, iv_req_addr, i_req_addr_fixed, iv_req_wdata,
    output i_rsp_wr, iv_rsp_addr, i_rsp_addr_fixed, iv_rsp_rdata,
    input  o_req_ready, o_wr, o_rd, ov_addr, o_addr_fixed, ov_wdata,
    input  o_rsp_valid, ov_rsp_rdata, o_rsp_err, ov_timeout_cnt
  );
endinterface
`default_nettype wire

// File: rtl/rsp_timeout_counter.sv
// rsp_timeout_counter: per-read wait counter plus saturating count of reads aborted by timeout.
`default_nettype none
module rsp_timeout_counter
  import register_access_pkg::*;
#(
  parameter int unsigned      TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter logic [CNT_W-1:0] STAT_INIT      = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_tick,
  input  logic             i_rsp_hit,
  output logic             o_expire,
  output logic [CNT_W-1:0] ov_timeout_cnt
);
  // Expiry fires on the last allowed wait cycle, i.e. when the count would reach TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] r_stat;

  // A response in the expiry cycle takes priority, so it suppresses the abort.
  assign o_expire       = i_tick & ~i_rsp_hit & (r_wait_cnt == c_LAST);
  assign ov_timeout_cnt = r_stat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
      r_stat     <= STAT_INIT;
    end else begin
      if (i_clear) begin
        r_wait_cnt <= '0;
      end else if (i_tick) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (o_expire && (r_stat != {CNT_W{1'b1}})) begin
        r_stat <= r_stat + 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/register_access_initiator.sv
// register_access_initiator: single-outstanding register bus initiator with read timeout.
// Optional macro RSP_ADDR_CHECK_EN: read responses with mismatching address/fixed flag complete with error.
`default_nettype none
module register_access_initiator
  import register_access_pkg::*;
#(
  parameter int unsigned      TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter logic [CNT_W-1:0] STAT_INIT      = '0
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  register_access_initiator_if.master bus_if
);
  state_t            r_state;
  logic              r_ready;
  logic              r_is_rd;
  logic [ADDR_W-1:0] r_addr;
  logic              r_addr_fixed;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wr;
  logic              r_rd;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              w_clear;
  logic              w_tick;
  logic              w_expire;
  logic              w_rsp_bad;
  logic [CNT_W-1:0]  w_timeout_cnt;

  assign w_clear = (r_state == ST_ISSUE);
  assign w_tick  = (r_state == ST_WAIT_RSP);

`ifdef RSP_ADDR_CHECK_EN
  assign w_rsp_bad = (bus_if.iv_rsp_addr != r_addr) || (bus_if.i_rsp_addr_fixed != r_addr_fixed);
`else
  assign w_rsp_bad = 1'b0;
`endif

  rsp_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .STAT_INIT      (STAT_INIT)
  ) u_rsp_timeout_counter (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_clear        (w_clear),
    .i_tick         (w_tick),
    .i_rsp_hit      (bus_if.i_rsp_wr),
    .o_expire       (w_expire),
    .ov_timeout_cnt (w_timeout_cnt)
  );

  // Ready is registered so it stays low through reset and rises on the first edge after release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b0;
      r_is_rd      <= 1'b0;
      r_addr       <= '0;
      r_addr_fixed <= 1'b0;
      r_wdata      <= '0;
      r_wr         <= 1'b0;
      r_rd         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (bus_if.i_req_valid && r_ready) begin
            r_ready      <= 1'b0;
            r_is_rd      <= bus_if.i_req_rd;
            r_addr       <= bus_if.iv_req_addr;
            r_addr_fixed <= bus_if.i_req_addr_fixed;
            r_wdata      <= bus_if.i_req_rd ? '0 : bus_if.iv_req_wdata;
            r_wr         <= ~bus_if.i_req_rd;
            r_rd         <= bus_if.i_req_rd;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_is_rd) begin
            r_state <= ST_WAIT_RSP;
          end else begin
            r_rsp_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_WAIT_RSP: begin
          if (bus_if.i_rsp_wr) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_rsp_bad;
            r_rsp_rdata <= w_rsp_bad ? '0 : bus_if.iv_rsp_rdata;
            r_state     <= ST_DONE;
          end else if (w_expire) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_if.o_req_ready    = r_ready;
  assign bus_if.o_wr           = r_wr;
  assign bus_if.o_rd           = r_rd;
  assign bus_if.ov_addr        = r_addr;
  assign bus_if.o_addr_fixed   = r_addr_fixed;
  assign bus_if.ov_wdata       = r_wdata;
  assign bus_if.o_rsp_valid    = r_rsp_valid;
  assign bus_if.ov_rsp_rdata   = r_rsp_rdata;
  assign bus_if.o_rsp_err      = r_rsp_err;
  assign bus_if.ov_timeout_cnt = w_timeout_cnt;
endmodule
`default_nettype wire

// File: tb/tb_register_access_initiator.sv
// tb_register_access_initiator: directed table, randomized transactions against a transaction-level model.
`default_nettype none
module tb_register_access_initiator;
  import register_access_pkg::*;

  localparam int TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  register_access_initiator_if bus_a ();
  register_access_initiator_if bus_b ();

  register_access_initiator #(.TIMEOUT_CYCLES(TO)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus_if(bus_a)
  );
  register_access_initiator #(.TIMEOUT_CYCLES(TO), .STAT_INIT(16'hFFFF)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus_if(bus_b)
  );

  typedef struct {
    bit          rd;
    logic [18:0] addr;
    bit          fixed;
    logic [31:0] wdata;
    int          dly;    // wait cycles before the response; >= TO means never
    logic [18:0] raddr;
    bit          rfixed;
    logic [31:0] rdata;
    int          lat;    // expected cycles from accept to completion
    bit          err;
    logic [31:0] xdata;
  } vec_t;

  int n_vec    = 0;
  int n_err    = 0;
  int exp_stat = 0;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit rd, input logic [18:0] addr, input bit fixed,
                              input logic [31:0] wdata, input int dly, input logic [18:0] raddr,
                              input bit rfixed, input logic [31:0] rdata, input int lat,
                              input bit err, input logic [31:0] xdata);
    vec_t v;
    v.rd = rd; v.addr = addr; v.fixed = fixed; v.wdata = wdata; v.dly = dly;
    v.raddr = raddr; v.rfixed = rfixed; v.rdata = rdata;
    v.lat = lat; v.err = err; v.xdata = xdata;
    return v;
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit mism;
`ifdef RSP_ADDR_CHECK_EN
    mism = (v.raddr != v.addr) || (v.rfixed != v.fixed);
`else
    mism = 1'b0;
`endif
    if (!v.rd) begin
      r.lat = 2; r.err = 1'b0; r.xdata = '0;
    end else if (v.dly >= TO) begin
      r.lat = 2 + TO; r.err = 1'b1; r.xdata = '0;
    end else begin
      r.lat = 3 + v.dly; r.err = mism; r.xdata = mism ? 32'h0 : v.rdata;
    end
    return r;
  endfunction

  task automatic junk_rsp(input bit allow_wr);
    bus_a.i_rsp_wr         = allow_wr ? 1'($urandom) : 1'b0;
    bus_a.iv_rsp_addr      = 19'($urandom);
    bus_a.i_rsp_addr_fixed = 1'($urandom);
    bus_a.iv_rsp_rdata     = $urandom;
  endtask

  task automatic run_txn(input vec_t v);
    bit to = v.rd && (v.dly >= TO);
    @(posedge clk); #1;
    bus_a.i_req_valid = 1'b1; bus_a.i_req_rd = v.rd; bus_a.iv_req_addr = v.addr;
    bus_a.i_req_addr_fixed = v.fixed; bus_a.iv_req_wdata = v.wdata;
    junk_rsp(1'b1);
    @(negedge clk);
    chk("ready_accept", bus_a.o_req_ready, 1);
    chk("stat_idle", bus_a.ov_timeout_cnt, exp_stat);
    @(posedge clk); #1;
    bus_a.i_req_valid = 1'b0; bus_a.iv_req_wdata = $urandom; bus_a.iv_req_addr = 19'($urandom);
    junk_rsp(1'b1);
    @(negedge clk);
    chk("issue_wr", bus_a.o_wr, !v.rd);
    chk("issue_rd", bus_a.o_rd, v.rd);
    chk("issue_addr", bus_a.ov_addr, v.addr);
    chk("issue_fixed", bus_a.o_addr_fixed, v.fixed);
    chk("issue_wdata", bus_a.ov_wdata, v.rd ? 32'h0 : v.wdata);
    chk("issue_ready", bus_a.o_req_ready, 0);
    for (int k = 2; k <= v.lat; k++) begin
      @(posedge clk); #1;
      if (v.rd && k < v.lat) begin
        junk_rsp(1'b0);
        if (k == 2 + v.dly) begin
          bus_a.i_rsp_wr = 1'b1; bus_a.iv_rsp_addr = v.raddr;
          bus_a.i_rsp_addr_fixed = v.rfixed; bus_a.iv_rsp_rdata = v.rdata;
        end
      end else begin
        junk_rsp(1'b1);
      end
      @(negedge clk);
      if (k < v.lat) begin
        chk("wait_valid", {bus_a.o_rsp_valid, bus_a.o_rsp_err, bus_a.ov_rsp_rdata}, 0);
        chk("wait_strobes", {bus_a.o_wr, bus_a.o_rd, bus_a.o_req_ready}, 0);
      end else begin
        if (to && exp_stat != 65535) exp_stat++;
        chk("done_valid", bus_a.o_rsp_valid, 1);
        chk("done_err", bus_a.o_rsp_err, v.err);
        chk("done_rdata", bus_a.ov_rsp_rdata, v.xdata);
        chk("done_stat", bus_a.ov_timeout_cnt, exp_stat);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, bus_a.o_req_ready, 0);
    chk({tag, "_cmd"}, {bus_a.o_wr, bus_a.o_rd, bus_a.o_addr_fixed, bus_a.ov_addr, bus_a.ov_wdata}, 0);
    chk({tag, "_rsp"}, {bus_a.o_rsp_valid, bus_a.o_rsp_err, bus_a.ov_rsp_rdata}, 0);
    chk({tag, "_stat"}, bus_a.ov_timeout_cnt, 0);
  endtask

  initial begin
    vec_t v;
    bit   seen;
    bus_a.i_req_valid = 0; bus_a.i_req_rd = 0; bus_a.iv_req_addr = 0;
    bus_a.i_req_addr_fixed = 0; bus_a.iv_req_wdata = 0;
    bus_a.i_rsp_wr = 0; bus_a.iv_rsp_addr = 0; bus_a.i_rsp_addr_fixed = 0; bus_a.iv_rsp_rdata = 0;
    bus_b.i_req_valid = 0; bus_b.i_req_rd = 0; bus_b.iv_req_addr = 0;
    bus_b.i_req_addr_fixed = 0; bus_b.iv_req_wdata = 0;
    bus_b.i_rsp_wr = 0; bus_b.iv_rsp_addr = 0; bus_b.i_rsp_addr_fixed = 0; bus_b.iv_rsp_rdata = 0;

    tbl[0] = mk(0, 19'h0, 0, 32'hA5A5_0001, 0, 19'h0, 0, 32'h0, 2, 0, 32'h0);
    tbl[1] = mk(1, 19'h0, 1, 32'hFFFF_FFFF, 0, 19'h0, 1, 32'h0000_0123, 3, 0, 32'h0000_0123);
    tbl[2] = mk(1, 19'h0, 0, 32'h0, 99, 19'h0, 0, 32'h0, 2 + TO, 1, 32'h0);
`ifdef RSP_ADDR_CHECK_EN
    tbl[3] = mk(1, 19'h0, 0, 32'h0, 0, 19'h1, 0, 32'hDEAD_BEEF, 3, 1, 32'h0);
`else
    tbl[3] = mk(1, 19'h0, 0, 32'h0, 0, 19'h1, 0, 32'hDEAD_BEEF, 3, 0, 32'hDEAD_BEEF);
`endif
    tbl[4] = mk(1, 19'h2_3456, 0, 32'h0, TO - 1, 19'h2_3456, 0, 32'hCAFE_F00D, 2 + TO, 0, 32'hCAFE_F00D);
    tbl[5] = mk(0, 19'h7_FFFF, 1, 32'hFFFF_FFFF, 0, 19'h0, 0, 32'h0, 2, 0, 32'h0);

    #1 rst_n = 1'b0;
    #2 chk_all_zero("reset");
    #9 rst_n = 1'b1;

    // Preloaded statistic must saturate rather than wrap on a timeout.
    @(posedge clk); #1;
    bus_b.i_req_valid = 1'b1; bus_b.i_req_rd = 1'b1;
    @(negedge clk);
    chk("b_ready", bus_b.o_req_ready, 1);
    chk("b_stat_init", bus_b.ov_timeout_cnt, 16'hFFFF);
    @(posedge clk); #1;
    bus_b.i_req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus_b.o_rsp_valid) begin
        seen = 1'b1;
        chk("b_err", bus_b.o_rsp_err, 1);
        chk("b_rdata", bus_b.ov_rsp_rdata, 0);
        chk("b_stat_sat", bus_b.ov_timeout_cnt, 16'hFFFF);
      end
    end
    if (!seen) chk("b_completion_seen", 0, 1);

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      v.rd = 1'($urandom); v.addr = 19'($urandom); v.fixed = 1'($urandom);
      v.wdata = $urandom; v.dly = int'($urandom_range(0, TO + 1));
      v.raddr = ($urandom_range(0, 3) == 0) ? (v.addr ^ (19'h1 << $urandom_range(0, 18))) : v.addr;
      v.rfixed = ($urandom_range(0, 4) == 0) ? !v.fixed : v.fixed;
      v.rdata = $urandom;
      run_txn(model(v));
    end

    // Stray response in IDLE, then reset while waiting on a read.
    @(posedge clk); #1;
    bus_a.i_rsp_wr = 1'b1; bus_a.iv_rsp_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("stray_ready", bus_a.o_req_ready, 1);
    @(posedge clk); #1;
    bus_a.i_rsp_wr = 1'b0;
    @(negedge clk);
    chk("stray_valid", bus_a.o_rsp_valid, 0);
    chk("stray_ready2", bus_a.o_req_ready, 1);
    @(posedge clk); #1;
    bus_a.i_req_valid = 1'b1; bus_a.i_req_rd = 1'b1; bus_a.iv_req_addr = 19'h55;
    @(posedge clk); #1;
    bus_a.i_req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_stat = 0;
    #1 chk_all_zero("midrst");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      bus_a.i_rsp_wr = 1'b1; bus_a.iv_rsp_rdata = $urandom;
      @(negedge clk);
      chk("postrst_valid", {bus_a.o_rsp_valid, bus_a.o_rsp_err, bus_a.ov_rsp_rdata}, 0);
      chk("postrst_cmd", {bus_a.o_wr, bus_a.o_rd}, 0);
    end
    chk("postrst_ready", bus_a.o_req_ready, 1);
    bus_a.i_rsp_wr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
